// File: rtl/uimac_tx_pause_gate_pkg.sv
// Shared definitions for the MAC TX pause gate and the RX control-frame parser.
package uimac_tx_pause_gate_pkg;

  // Default pause-time width in byte-clock cycles
  localparam int PAUSE_W_DEF = 22;

  // MAC control opcode that identifies a PAUSE frame
  localparam logic [15:0] PAUSE_OPCODE = 16'h0001;

  // State encoding
  localparam logic [1:0] ST_IDLE_ENC       = 2'd0;
  localparam logic [1:0] ST_TX_ACTIVE_ENC  = 2'd1;
  localparam logic [1:0] ST_PAUSE_WAIT_ENC = 2'd2;
  localparam logic [1:0] ST_PAUSED_ENC     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = ST_IDLE_ENC,
    ST_TX_ACTIVE  = ST_TX_ACTIVE_ENC,
    ST_PAUSE_WAIT = ST_PAUSE_WAIT_ENC,
    ST_PAUSED     = ST_PAUSED_ENC
  } gate_state_t;

  // True when a MAC control opcode denotes a PAUSE frame
  function automatic logic is_pause_opcode(input logic [15:0] opcode);
    return (opcode == PAUSE_OPCODE);
  endfunction

endpackage

// File: rtl/uimac_pause_cnt.sv
// Pause down-counter: load, decrement, clear, and a terminal flag at 1.
// The owner exits on the terminal flag, so the count never wraps below 0.
module uimac_pause_cnt
  import uimac_tx_pause_gate_pkg::*;
#(
  parameter int PAUSE_W = PAUSE_W_DEF
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic               load,
  input  logic [PAUSE_W-1:0] load_val,
  input  logic               dec,
  input  logic               clr,
  output logic [PAUSE_W-1:0] cnt,
  output logic               term
);

  // Counter register: clear beats load, load beats decrement
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - PAUSE_W'(1);
    end
  end

  assign term = (cnt == PAUSE_W'(1));

endmodule

// File: rtl/uimac_tx_pause_gate.sv
// TX pause gate: sits between the RX control-frame parser (pause_en /
// pause_time) and the TX frame scheduler. Grants frames while not paused,
// defers a PAUSE received mid-frame until the frame ends, and holds off
// transmission for the requested number of byte-clock cycles.
module uimac_tx_pause_gate
  import uimac_tx_pause_gate_pkg::*;
#(
  parameter int PAUSE_W = PAUSE_W_DEF
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic               I_pause_en,
  input  logic [PAUSE_W-1:0] I_pause_time,
  input  logic               I_tx_req,
  output logic               O_tx_grant,
  input  logic               I_tx_frame_end,
  output logic               O_tx_paused,
  output logic [PAUSE_W-1:0] O_pause_cnt
);

  gate_state_t        state, state_nxt;
  logic [PAUSE_W-1:0] pend, pend_nxt;
  logic               grant_nxt;
  logic               valid_pause, cancel;

  logic               cnt_load, cnt_dec, cnt_clr, cnt_term;
  logic [PAUSE_W-1:0] cnt_load_val, cnt_q;

  assign valid_pause = I_pause_en && (I_pause_time != '0);
  assign cancel      = I_pause_en && (I_pause_time == '0);

  uimac_pause_cnt #(.PAUSE_W(PAUSE_W)) u_cnt (
    .I_clk    (I_clk),
    .I_reset  (I_reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .cnt      (cnt_q),
    .term     (cnt_term)
  );

  // Next-state, pending-time and counter-control decode
  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend;
    grant_nxt    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = I_pause_time;
    cnt_dec      = 1'b0;
    cnt_clr      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid_pause) begin
          cnt_load  = 1'b1;
          state_nxt = ST_PAUSED;
        end else if (I_tx_req) begin
          grant_nxt = 1'b1;
          state_nxt = ST_TX_ACTIVE;
        end
      end
      ST_TX_ACTIVE: begin
        if (I_tx_frame_end) begin
          if (valid_pause) begin
            cnt_load  = 1'b1;
            state_nxt = ST_PAUSED;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (valid_pause) begin
          pend_nxt  = I_pause_time;
          state_nxt = ST_PAUSE_WAIT;
        end
      end
      ST_PAUSE_WAIT: begin
        if (I_tx_frame_end) begin
          pend_nxt = '0;
          if (valid_pause) begin
            cnt_load  = 1'b1;
            state_nxt = ST_PAUSED;
          end else if (cancel) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = pend;
            state_nxt    = ST_PAUSED;
          end
        end else if (valid_pause) begin
          pend_nxt = I_pause_time;
        end else if (cancel) begin
          pend_nxt  = '0;
          state_nxt = ST_TX_ACTIVE;
        end
      end
      ST_PAUSED: begin
        if (valid_pause) begin
          cnt_load = 1'b1;
        end else if (cancel || cnt_term) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        cnt_clr   = 1'b1;
        pend_nxt  = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pending time and registered grant/paused outputs
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state       <= ST_IDLE;
      pend        <= '0;
      O_tx_grant  <= 1'b0;
      O_tx_paused <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend        <= pend_nxt;
      O_tx_grant  <= grant_nxt;
      O_tx_paused <= (state_nxt == ST_PAUSED);
    end
  end

  // The counter is cleared on every exit from PAUSED and loaded only on
  // entry, so its register already reads 0 in every other state.
  assign O_pause_cnt = cnt_q;

endmodule

// File: tb/tb_uimac_tx_pause_gate.sv
// Testbench for uimac_tx_pause_gate: directed scenarios plus random traffic,
// compared against a behavioural model of frames, pending pause and
// remaining pause time.
module tb_uimac_tx_pause_gate;

  localparam int PW = 22;

  logic          I_clk = 1'b0;
  logic          I_reset = 1'b1;
  logic          I_pause_en = 1'b0;
  logic [PW-1:0] I_pause_time = '0;
  logic          I_tx_req = 1'b0;
  logic          I_tx_frame_end = 1'b0;
  logic          O_tx_grant;
  logic          O_tx_paused;
  logic [PW-1:0] O_pause_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Behavioural model: remaining pause cycles, frame in flight, deferred pause
  int m_left = 0;
  int m_pend = 0;
  bit m_frame = 0;
  bit m_grant = 0;

  uimac_tx_pause_gate #(.PAUSE_W(PW)) dut (
    .I_clk          (I_clk),
    .I_reset        (I_reset),
    .I_pause_en     (I_pause_en),
    .I_pause_time   (I_pause_time),
    .I_tx_req       (I_tx_req),
    .O_tx_grant     (O_tx_grant),
    .I_tx_frame_end (I_tx_frame_end),
    .O_tx_paused    (O_tx_paused),
    .O_pause_cnt    (O_pause_cnt)
  );

  always #5 I_clk = ~I_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW+1:0] exp_vec();
    return {m_grant, (m_left > 0), PW'(m_left)};
  endfunction

  function automatic logic [PW+1:0] obs_vec();
    return {O_tx_grant, O_tx_paused, O_pause_cnt};
  endfunction

  task automatic model_reset();
    m_left = 0; m_pend = 0; m_frame = 0; m_grant = 0;
  endtask

  task automatic model_step(input bit pe, input int pt, input bit req, input bit fe);
    bit valid, canc;
    valid = pe && (pt != 0);
    canc  = pe && (pt == 0);
    m_grant = 0;
    if (m_left > 0) begin
      if (valid)     m_left = pt;
      else if (canc) m_left = 0;
      else           m_left = m_left - 1;
    end else if (m_frame) begin
      if (fe) begin
        m_frame = 0;
        if (valid)              m_left = pt;
        else if (!canc && m_pend != 0) m_left = m_pend;
        m_pend = 0;
      end else if (valid) begin
        m_pend = pt;
      end else if (canc) begin
        m_pend = 0;
      end
    end else begin
      if (valid) m_left = pt;
      else if (req) begin
        m_grant = 1;
        m_frame = 1;
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, settle outputs
  task automatic step(input bit pe, input int pt, input bit req, input bit fe);
    I_pause_en = pe;
    I_pause_time = PW'(pt);
    I_tx_req = req;
    I_tx_frame_end = fe;
    @(posedge I_clk);
    cyc++;
    if (I_reset) model_reset();
    else model_step(pe, pt, req, fe);
    #1;
    I_pause_en = 1'b0;
    I_tx_frame_end = 1'b0;
  endtask

  task automatic test_reset();
    I_reset = 1'b1;
    model_reset();
    step(0, 0, 1, 0);
    step(1, 7, 1, 0);
    n_cmp++;
    if (obs_vec() !== '0) begin
      n_bad++;
      $display("FAIL reset_state got=%h want=0", obs_vec());
    end
    I_reset = 1'b0;
    step(0, 0, 0, 0);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_release got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_idle_grant();
    step(0, 0, 1, 0);
    n_cmp++;
    if (O_tx_grant !== 1'b1 || O_tx_paused !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL idle_grant got=%h want=%h", obs_vec(), exp_vec());
    end
    step(0, 0, 1, 0);
    n_cmp++;
    if (O_tx_grant !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL grant_one_cycle got=%h want=%h", obs_vec(), exp_vec());
    end
    step(0, 0, 0, 1);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL frame_end_idle got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_pause_idle();
    int pc;
    step(1, 100, 1, 0);
    pc = 0;
    while (O_tx_paused && pc < 300) begin
      n_cmp++;
      if (O_pause_cnt !== PW'(100 - pc) || obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL pause_idle_cnt pc=%0d got=%h want=%0d", pc, O_pause_cnt, 100 - pc);
      end
      step(0, 0, 1, 0);
      pc++;
    end
    n_cmp++;
    if (pc != 100) begin
      n_bad++;
      $display("FAIL pause_idle_len got=%0d want=100", pc);
    end
    step(0, 0, 1, 0);
    n_cmp++;
    if (O_tx_grant !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL pause_idle_grant got=%h want=%h", obs_vec(), exp_vec());
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_mid_frame();
    int pc;
    step(0, 0, 1, 0);
    for (int b = 1; b <= 60; b++) begin
      step(b == 10, 64, 0, b == 60);
      n_cmp++;
      if ((b < 60 && O_tx_paused !== 1'b0) || obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL mid_frame byte=%0d got=%h want=%h", b, obs_vec(), exp_vec());
      end
    end
    pc = 0;
    while (O_tx_paused && pc < 300) begin
      n_cmp++;
      if (O_pause_cnt !== PW'(64 - pc)) begin
        n_bad++;
        $display("FAIL mid_frame_cnt pc=%0d got=%0d want=%0d", pc, O_pause_cnt, 64 - pc);
      end
      step(0, 0, 0, 0);
      pc++;
    end
    n_cmp++;
    if (pc != 64) begin
      n_bad++;
      $display("FAIL mid_frame_len got=%0d want=64", pc);
    end
  endtask

  task automatic test_reload_cancel();
    int guard;
    step(1, 100, 0, 0);
    guard = 0;
    while (O_pause_cnt != PW'(30) && guard < 200) begin
      step(0, 0, 0, 0);
      guard++;
    end
    n_cmp++;
    if (O_pause_cnt !== PW'(30)) begin
      n_bad++;
      $display("FAIL reload_reach30 got=%0d want=30", O_pause_cnt);
    end
    step(1, 500, 0, 0);
    n_cmp++;
    if (O_pause_cnt !== PW'(500) || O_tx_paused !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL reload_500 got=%0d want=500", O_pause_cnt);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    n_cmp++;
    if (O_tx_paused !== 1'b0 || O_pause_cnt !== '0 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL cancel got=%h want=0", obs_vec());
    end
  endtask

  task automatic test_simultaneous();
    int pc;
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 20, 0, 1);
    pc = 0;
    while (O_tx_paused && pc < 100) begin
      step(0, 0, 0, 0);
      pc++;
    end
    n_cmp++;
    if (pc != 20 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL simul_tx_active got=%0d want=20", pc);
    end
    step(0, 0, 1, 0);
    step(1, 50, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    n_cmp++;
    if (O_tx_paused !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_wait_paused got=%b want=0", O_tx_paused);
    end
    step(1, 8, 0, 1);
    pc = 0;
    while (O_tx_paused && pc < 100) begin
      step(0, 0, 0, 0);
      pc++;
    end
    n_cmp++;
    if (pc != 8 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL simul_pause_wait got=%0d want=8", pc);
    end
  endtask

  task automatic test_reset_mid_pause();
    int guard;
    step(1, 250, 1, 0);
    guard = 0;
    while (O_pause_cnt != PW'(200) && guard < 300) begin
      step(0, 0, 1, 0);
      guard++;
    end
    #2;
    I_reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec() !== '0 || guard >= 300) begin
      n_bad++;
      $display("FAIL reset_async got=%h want=0", obs_vec());
    end
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    I_reset = 1'b0;
    step(0, 0, 1, 0);
    n_cmp++;
    if (O_tx_grant !== 1'b1 || O_tx_paused !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_regrant got=%h want=%h", obs_vec(), exp_vec());
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit pe, req, fe;
    int pt;
    for (int i = 0; i < 4000; i++) begin
      pe  = ($urandom_range(0, 11) == 0);
      pt  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      req = $urandom_range(0, 1);
      fe  = ($urandom_range(0, 5) == 0);
      step(pe, pt, req, fe);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_grant();
    test_pause_idle();
    test_mid_frame();
    test_reload_cancel();
    test_simultaneous();
    test_reset_mid_pause();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
